// File: rtl/databus_arb_pkg.sv
// Shared types and helpers for the databus round-robin arbiter.
//   arb_state_e : arbiter FSM state (IDLE, BUSY)
//   GRANT_NONE  : all-zero grant vector, wide enough for the largest N_REQ
//   ptr_width() : width of the rr pointer / grant index ($clog2, minimum 1)
package databus_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_REQ = 16;
  localparam logic [MAX_REQ-1:0] GRANT_NONE = '0;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/databus_rr_picker.sv
// Combinational grant picker: rotate the valid vector so the rr pointer sits at bit 0,
// priority-encode the lowest set bit, then un-rotate back to a requester index.
// Optional macro DATABUS_ARB_PRIORITY_EN adds prio_mask; any valid requester with its
// prio bit set wins (lowest index first), bypassing the rotation.
// Ports:
//   valid     in  N_REQ  request vector
//   rr_ptr    in  PTR_W  round-robin start index
//   prio_mask in  N_REQ  priority requesters (DATABUS_ARB_PRIORITY_EN only)
//   grant     out N_REQ  one-hot pick, zero if nothing valid
//   grant_idx out PTR_W  binary index of the pick
//   any_valid out 1      at least one requester valid
//   prio_hit  out 1      pick came from the priority path
module databus_rr_picker
  import databus_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] rr_ptr,
`ifdef DATABUS_ARB_PRIORITY_EN
  input  logic [N_REQ-1:0] prio_mask,
`endif
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_valid,
  output logic             prio_hit
);

  logic [2*N_REQ-1:0] valid_dbl;
  logic [N_REQ-1:0]   rotated;
  logic [PTR_W-1:0]   rot_idx;
  logic [PTR_W:0]     unrot_sum;

  always_comb begin
    valid_dbl = {valid, valid};
    rotated   = N_REQ'(valid_dbl >> rr_ptr);

    // Descending scan so the lowest set bit is the last (winning) write.
    rot_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        rot_idx = PTR_W'(i);
      end
    end

    // Explicit modulo: sum of two indices is below 2*N_REQ.
    unrot_sum = {1'b0, rot_idx} + {1'b0, rr_ptr};
    if (unrot_sum >= (PTR_W + 1)'(N_REQ)) begin
      unrot_sum = unrot_sum - (PTR_W + 1)'(N_REQ);
    end

    any_valid = |valid;
    grant_idx = unrot_sum[PTR_W-1:0];
    prio_hit  = 1'b0;

`ifdef DATABUS_ARB_PRIORITY_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (valid[i] && prio_mask[i]) begin
        grant_idx = PTR_W'(i);
        prio_hit  = 1'b1;
      end
    end
`endif

    grant = '0;
    if (any_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/databus_rr_arbiter.sv
// Round-robin arbiter sharing one unit-side databus master port among N_REQ requesters.
// A grant is taken in IDLE and held for the whole burst, until a beat with ready & last.
// Optional macro DATABUS_ARB_PRIORITY_EN adds prio_mask_i; priority grants do not move
// the rr pointer.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid_i / req_ready_o  per-requester valid and beat strobe
//   req_last_o                 per-requester last-beat strobe
//   req_addr_i/len_i/wdata_i/wstrb_i  packed per-requester command/write fields
//   req_rdata_o                read data broadcast to every requester
//   databus_*                  shared bus-side port (muxed from the granted requester)
//   grant_o                    one-hot current grant, zero when idle
//   busy_o                     high while a burst is granted
//   prio_mask_i                priority requesters (DATABUS_ARB_PRIORITY_EN only)
module databus_rr_arbiter
  import databus_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid_i,
  output logic [N_REQ-1:0]                req_ready_o,
  output logic [N_REQ-1:0]                req_last_o,
  input  logic [N_REQ*AXI_ADDR_W-1:0]     req_addr_i,
  input  logic [N_REQ*LEN_W-1:0]          req_len_i,
  input  logic [N_REQ*AXI_DATA_W-1:0]     req_wdata_i,
  input  logic [N_REQ*AXI_DATA_W/8-1:0]   req_wstrb_i,
  output logic [AXI_DATA_W-1:0]           req_rdata_o,
  output logic                            databus_valid_o,
  input  logic                            databus_ready_i,
  output logic [AXI_ADDR_W-1:0]           databus_addr_o,
  output logic [LEN_W-1:0]                databus_len_o,
  output logic [AXI_DATA_W-1:0]           databus_wdata_o,
  output logic [AXI_DATA_W/8-1:0]         databus_wstrb_o,
  input  logic [AXI_DATA_W-1:0]           databus_rdata_i,
  input  logic                            databus_last_i,
`ifdef DATABUS_ARB_PRIORITY_EN
  input  logic [N_REQ-1:0]                prio_mask_i,
`endif
  output logic [N_REQ-1:0]                grant_o,
  output logic                            busy_o
);

  localparam int unsigned PTR_W  = ptr_width(N_REQ);
  localparam int unsigned STRB_W = AXI_DATA_W / 8;

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             prio_q, prio_d;
  logic             busy;

  logic [N_REQ-1:0] pick_grant;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             pick_prio;
  logic [PTR_W-1:0] rr_after;

  databus_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .valid     (req_valid_i),
    .rr_ptr    (rr_ptr_q),
`ifdef DATABUS_ARB_PRIORITY_EN
    .prio_mask (prio_mask_i),
`endif
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any),
    .prio_hit  (pick_prio)
  );

  assign busy     = (state_q == BUSY);
  // Compare-based wrap so non-power-of-two N_REQ rotates correctly.
  assign rr_after = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    prio_d   = prio_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          grant_d = pick_grant;
          gidx_d  = pick_idx;
          prio_d  = pick_prio;
        end
      end
      BUSY: begin
        if (databus_ready_i && databus_last_i) begin
          state_d = IDLE;
          grant_d = GRANT_NONE[N_REQ-1:0];
          if (!prio_q) begin
            rr_ptr_d = rr_after;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= GRANT_NONE[N_REQ-1:0];
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      prio_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      prio_q   <= prio_d;
    end
  end

  // Bus-side mux; everything reads zero while idle so stale gidx_q never leaks.
  always_comb begin
    databus_valid_o = 1'b0;
    databus_addr_o  = '0;
    databus_len_o   = '0;
    databus_wdata_o = '0;
    databus_wstrb_o = '0;
    if (busy) begin
      databus_valid_o = req_valid_i[gidx_q];
      databus_addr_o  = req_addr_i[gidx_q*AXI_ADDR_W +: AXI_ADDR_W];
      databus_len_o   = req_len_i[gidx_q*LEN_W +: LEN_W];
      databus_wdata_o = req_wdata_i[gidx_q*AXI_DATA_W +: AXI_DATA_W];
      databus_wstrb_o = req_wstrb_i[gidx_q*STRB_W +: STRB_W];
    end
  end

  assign req_ready_o = grant_q & {N_REQ{databus_ready_i & busy}};
  assign req_last_o  = grant_q & {N_REQ{databus_ready_i & databus_last_i & busy}};
  assign req_rdata_o = databus_rdata_i;
  assign grant_o     = grant_q;
  assign busy_o      = busy;

endmodule

// File: tb/tb_databus_rr_arbiter.sv
`timescale 1ns/1ps
module tb_databus_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready_o;
  logic [N-1:0]    req_last_o;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [DW-1:0]   req_rdata_o;
  logic            databus_valid_o;
  logic            databus_ready;
  logic [AW-1:0]   databus_addr_o;
  logic [LW-1:0]   databus_len_o;
  logic [DW-1:0]   databus_wdata_o;
  logic [SW-1:0]   databus_wstrb_o;
  logic [DW-1:0]   databus_rdata;
  logic            databus_last;
  logic [N-1:0]    grant_o;
  logic            busy_o;
`ifdef DATABUS_ARB_PRIORITY_EN
  logic [N-1:0]    prio_mask;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0] exp_q[$];

  databus_rr_arbiter #(
    .N_REQ      (N),
    .AXI_ADDR_W (AW),
    .AXI_DATA_W (DW),
    .LEN_W      (LW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready_o),
    .req_last_o      (req_last_o),
    .req_addr_i      (req_addr),
    .req_len_i       (req_len),
    .req_wdata_i     (req_wdata),
    .req_wstrb_i     (req_wstrb),
    .req_rdata_o     (req_rdata_o),
    .databus_valid_o (databus_valid_o),
    .databus_ready_i (databus_ready),
    .databus_addr_o  (databus_addr_o),
    .databus_len_o   (databus_len_o),
    .databus_wdata_o (databus_wdata_o),
    .databus_wstrb_o (databus_wstrb_o),
    .databus_rdata_i (databus_rdata),
    .databus_last_i  (databus_last),
`ifdef DATABUS_ARB_PRIORITY_EN
    .prio_mask_i     (prio_mask),
`endif
    .grant_o         (grant_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Bounded wait for a grant; g stays zero and cycles zero on timeout.
  task automatic wait_grant(output logic [N-1:0] g, output int cycles);
    int i;
    g = '0;
    cycles = 0;
    i = 0;
    while (i < 20 && cycles == 0) begin
      i++;
      step();
      if (grant_o != '0) begin
        g = grant_o;
        cycles = i;
      end
    end
  endtask

  // Drive one burst on the bus; record pulses seen by the granted requester.
  task automatic burst(input int beats, input logic [N-1:0] drop, output int rdy_cnt,
                       output logic [N-1:0] last_seen, output logic multi);
    logic [N-1:0] g;
    g = grant_o;
    rdy_cnt = 0;
    last_seen = '0;
    multi = 1'b0;
    for (int b = 0; b < beats; b++) begin
      databus_ready = 1'b1;
      databus_last  = (b == beats - 1);
      databus_rdata = 32'hA000_0000 + b;
      @(negedge clk);
      if (req_ready_o == g && g != '0) rdy_cnt++;
      last_seen = last_seen | req_last_o;
      if ($countones(grant_o) > 1) multi = 1'b1;
      step();
    end
    databus_ready = 1'b0;
    databus_last  = 1'b0;
    req_valid = req_valid & ~drop;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    req_valid = '1;
    databus_ready = 1'b1;
    databus_last = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant_o !== '0) begin
      n_fail++; $display("FAIL reset_grant got=%b exp=0", grant_o);
    end
    n_checks++;
    if (busy_o !== 1'b0 || databus_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_valid got=%b%b exp=00", busy_o, databus_valid_o);
    end
    n_checks++;
    if (req_ready_o !== '0 || req_last_o !== '0) begin
      n_fail++; $display("FAIL reset_ready_last got=%b/%b exp=0/0", req_ready_o, req_last_o);
    end
    n_checks++;
    if (databus_addr_o !== '0 || databus_len_o !== '0) begin
      n_fail++; $display("FAIL reset_mux got=%h/%h exp=0/0", databus_addr_o, databus_len_o);
    end
    step();
    rst = 1'b0;
    req_valid = '0;
    databus_ready = 1'b0;
    databus_last = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [N-1:0] g, ls, e;
    int cyc, rc;
    logic m;
    exp_q.push_back(4'b0010);
    req_valid = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (databus_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL single_latency_early got=%b exp=0", databus_valid_o);
    end
    wait_grant(g, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e || cyc != 1) begin
      n_fail++; $display("FAIL single_grant got=%b@%0d exp=%b@1", g, cyc, e);
    end
    n_checks++;
    if (databus_valid_o !== 1'b1 || databus_addr_o !== 32'h1000 || databus_len_o !== 16'd16) begin
      n_fail++;
      $display("FAIL single_mux got=%b/%h/%0d exp=1/00001000/16",
               databus_valid_o, databus_addr_o, databus_len_o);
    end
    burst(4, 4'b0010, rc, ls, m);
    n_checks++;
    if (rc != 4 || ls !== 4'b0010) begin
      n_fail++; $display("FAIL single_beats got=%0d/%b exp=4/0010", rc, ls);
    end
    n_checks++;
    if (grant_o !== '0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL single_release got=%b/%b exp=0/0", grant_o, busy_o);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g, ls, e;
    int cyc, rc, total;
    logic m, any_multi;
    do_reset();
    total = 0;
    any_multi = 1'b0;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++; $display("FAIL rr_order[%0d] got=%b exp=%b", k, g, e);
      end
      burst(2, (k == 4) ? 4'b1111 : 4'b0000, rc, ls, m);
      total += rc;
      any_multi = any_multi | m;
    end
    n_checks++;
    if (any_multi !== 1'b0 || total != 10) begin
      n_fail++; $display("FAIL rr_onehot_beats got=%b/%0d exp=0/10", any_multi, total);
    end
  endtask

  task automatic test_mid_burst();
    logic [N-1:0] g, ls, e;
    int cyc, rc;
    logic m;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    req_valid = 4'b0100;
    wait_grant(g, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e) begin
      n_fail++; $display("FAIL mid_first got=%b exp=%b", g, e);
    end
    n_checks++;
    if (databus_addr_o !== 32'h2000 || databus_wdata_o !== 32'hC0DE0002 ||
        databus_wstrb_o !== 4'hF) begin
      n_fail++;
      $display("FAIL mid_mux got=%h/%h/%h exp=00002000/c0de0002/f",
               databus_addr_o, databus_wdata_o, databus_wstrb_o);
    end
    req_valid[0] = 1'b1;
    burst(2, 4'b0000, rc, ls, m);
    wait_grant(g, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e || cyc != 1) begin
      n_fail++; $display("FAIL mid_second got=%b@%0d exp=%b@1", g, cyc, e);
    end
    burst(2, 4'b0001, rc, ls, m);
    wait_grant(g, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e || cyc != 1) begin
      n_fail++; $display("FAIL mid_regrant got=%b@%0d exp=%b@1", g, cyc, e);
    end
    burst(1, 4'b0100, rc, ls, m);
  endtask

  task automatic test_rst_mid_burst();
    logic [N-1:0] g, ls, e;
    int cyc, rc;
    logic m;
    exp_q.push_back(4'b1000);
    req_valid = 4'b1000;
    wait_grant(g, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e) begin
      n_fail++; $display("FAIL rstmid_grant got=%b exp=%b", g, e);
    end
    databus_ready = 1'b1;
    databus_last = 1'b0;
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (grant_o !== '0 || busy_o !== 1'b0 || databus_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state got=%b/%b/%b exp=0/0/0", grant_o, busy_o, databus_valid_o);
    end
    n_checks++;
    if (req_ready_o !== '0 || databus_addr_o !== '0) begin
      n_fail++; $display("FAIL rstmid_outs got=%b/%h exp=0/0", req_ready_o, databus_addr_o);
    end
    rst = 1'b0;
    databus_ready = 1'b0;
    req_valid = '0;
    step();
    exp_q.push_back(4'b0010);
    req_valid = 4'b1010;
    wait_grant(g, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e) begin
      n_fail++; $display("FAIL rstmid_ptr got=%b exp=%b", g, e);
    end
    burst(1, 4'b1010, rc, ls, m);
  endtask

  task automatic test_idle_inputs();
    logic [N-1:0] g, ls, e;
    int cyc, rc;
    logic m;
    databus_ready = 1'b1;
    databus_last = 1'b1;
    databus_rdata = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready_o !== '0 || req_last_o !== '0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_ignore[%0d] got=%b/%b/%b exp=0/0/0", k, req_ready_o, req_last_o,
                 busy_o);
      end
      step();
    end
    n_checks++;
    if (req_rdata_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL idle_rdata got=%h exp=deadbeef", req_rdata_o);
    end
    databus_ready = 1'b0;
    databus_last = 1'b0;
    exp_q.push_back(4'b1000);
    req_valid = 4'b1010;
    wait_grant(g, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e) begin
      n_fail++; $display("FAIL idle_ptr_kept got=%b exp=%b", g, e);
    end
    burst(1, 4'b1010, rc, ls, m);
  endtask

  task automatic test_valid_drop();
    logic [N-1:0] g, ls, e;
    int cyc, rc;
    logic m;
    exp_q.push_back(4'b0001);
    req_valid = 4'b0001;
    wait_grant(g, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e) begin
      n_fail++; $display("FAIL drop_grant got=%b exp=%b", g, e);
    end
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (databus_valid_o !== 1'b0 || grant_o !== 4'b0001) begin
      n_fail++; $display("FAIL drop_held got=%b/%b exp=0/0001", databus_valid_o, grant_o);
    end
    step();
    req_valid = 4'b0001;
    burst(1, 4'b0001, rc, ls, m);
    n_checks++;
    if (rc != 1 || grant_o !== '0) begin
      n_fail++; $display("FAIL drop_finish got=%0d/%b exp=1/0", rc, grant_o);
    end
  endtask

`ifdef DATABUS_ARB_PRIORITY_EN
  task automatic test_prio();
    logic [N-1:0] g, ls, e;
    int cyc, rc;
    logic m;
    do_reset();
    prio_mask = 4'b1000;
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    req_valid = 4'b1010;
    wait_grant(g, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e) begin
      n_fail++; $display("FAIL prio_first got=%b exp=%b", g, e);
    end
    burst(1, 4'b1000, rc, ls, m);
    wait_grant(g, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e) begin
      n_fail++; $display("FAIL prio_second got=%b exp=%b", g, e);
    end
    burst(1, 4'b0010, rc, ls, m);
    prio_mask = '0;
    req_valid = 4'b0111;
    wait_grant(g, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e) begin
      n_fail++; $display("FAIL prio_ptr got=%b exp=%b", g, e);
    end
    burst(1, 4'b0111, rc, ls, m);
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    databus_ready = 1'b0;
    databus_last = 1'b0;
    databus_rdata = '0;
`ifdef DATABUS_ARB_PRIORITY_EN
    prio_mask = '0;
`endif
    for (int k = 0; k < N; k++) begin
      req_addr[k*AW +: AW]  = 32'h1000 * k;
      req_len[k*LW +: LW]   = 16'(8 * (k + 1));
      req_wdata[k*DW +: DW] = 32'hC0DE0000 | k;
      req_wstrb[k*SW +: SW] = (k == 2) ? 4'hF : 4'h0;
    end
    req_len[1*LW +: LW] = 16'd16;

    test_reset();
    test_single();
    test_round_robin();
    test_mid_burst();
    test_rst_mid_burst();
    test_idle_inputs();
    test_valid_drop();
`ifdef DATABUS_ARB_PRIORITY_EN
    test_prio();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/databus_rr_arbiter.md
Name: databus_rr_arbiter

Overview:
- Shares one unit-side databus master port (valid/ready/addr/len/rdata/wdata/wstrb/last) among N requesters, e.g. several read units inside one accelerator.
- Grants one requester at a time, round-robin.
- Holds the grant for a whole burst, until the beat where ready and last are both high.
- Sits between the units and the top-level databus-to-AXI bridge.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- AXI_ADDR_W, 32, address width
- AXI_DATA_W, 32, data width
- LEN_W, 16, burst length width in bytes

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  N_REQ  per-requester valid, held high until its last beat
- req_ready_o  out  N_REQ  per-requester beat strobe
- req_last_o  out  N_REQ  per-requester last beat
- req_addr_i  in  N_REQ*AXI_ADDR_W  packed addresses, requester k at slice k
- req_len_i  in  N_REQ*LEN_W  packed lengths
- req_wdata_i  in  N_REQ*AXI_DATA_W  packed write data
- req_wstrb_i  in  N_REQ*AXI_DATA_W/8  packed write strobes (all zero for reads)
- req_rdata_o  out  AXI_DATA_W  read data, broadcast to all requesters
- databus_valid_o  out  1  bus-side valid
- databus_ready_i  in  1  bus-side beat accept
- databus_addr_o  out  AXI_ADDR_W  muxed address
- databus_len_o  out  LEN_W  muxed length
- databus_wdata_o  out  AXI_DATA_W  muxed write data
- databus_wstrb_o  out  AXI_DATA_W/8  muxed write strobe
- databus_rdata_i  in  AXI_DATA_W  read data
- databus_last_i  in  1  final beat of burst
- grant_o  out  N_REQ  one-hot current grant; zero when idle
- busy_o  out  1  high in BUSY

Behaviour:
- Reset values (rst sampled on clk edge): state=IDLE, grant_o=0, busy_o=0, databus_valid_o=0, all req_ready_o/req_last_o=0, rr pointer=0.
- States:
  - IDLE: if any req_valid_i, register grant to the first valid index searching upward from the rr pointer (wrap modulo N_REQ); go to BUSY. Otherwise stay.
  - BUSY: bus outputs mux the granted requester's signals. databus_valid_o = req_valid_i[g].
  - BUSY exit: on databus_ready_i & databus_last_i, go to IDLE, clear grant, set rr pointer = (g+1) mod N_REQ.
- Grant latency: 1 cycle from req_valid_i to databus_valid_o. Minimum gap between consecutive bursts is 1 idle cycle.
- Routing: req_ready_o[g] = databus_ready_i & busy; req_last_o[g] = databus_last_i & databus_ready_i & busy. Non-granted requesters see 0. Both are combinational from the bus side.
- Muxed outputs are zero when idle.
- Grant is never revoked mid-burst:
  - If req_valid_i[g] drops before last, the grant is held and databus_valid_o follows it low (protocol error, not recovered).
  - databus_ready_i while idle is ignored.
- Simultaneous last on requester g and a new req_valid_i[g]: g goes to the back of rotation; other valid requesters are served first.
- Single active requester: re-granted every other cycle.
- rst mid-burst: immediate return to IDLE and all outputs to reset values; the bridge is responsible for discarding the partial burst.
- Width: rr pointer is $clog2(N_REQ) bits. Wrap is explicit compare-to-(N_REQ-1), not power-of-two overflow.

Optional Feature:
- Macro: DATABUS_ARB_PRIORITY_EN.
- When defined:
  - Adds input prio_mask_i [N_REQ].
  - In IDLE, if any valid requester has its prio bit set, grant goes to the lowest such index, ignoring the rr pointer.
  - The rr pointer is updated only on non-priority grants.
- When not defined: the port is absent and arbitration is pure round-robin.

Decomposition:
- Package databus_arb_pkg:
  - state enum IDLE=1'b0, BUSY=1'b1
  - function for pointer width ($clog2 with minimum 1)
  - localparam for the one-hot zero value
- One sub-module, databus_rr_picker: combinational.
  - Inputs: valid vector, rr pointer, optional prio mask.
  - Outputs: one-hot grant and grant index.
  - Implemented as a rotate, then a priority encoder, then an un-rotate.

Test Plan:
- Single requester 1 (addr 0x1000, len 16, 4 beats of ready, last on 4th) -> databus_valid_o rises 1 cycle after req_valid_i[1]; req_ready_o[1] pulses 4 times; req_last_o[1] on beat 4; grant_o returns to 0 the next cycle.
- All 4 valid together, each burst 2 beats -> grant order 0,1,2,3,0; never two bits of grant_o set.
- Requester 2 holds valid continuously, requester 0 asserts mid-burst of 2 -> next grant goes to 0, then 2.
- rst asserted on beat 2 of a 4-beat burst from requester 3 -> next cycle all outputs 0, state IDLE; rr pointer 0 after release.
- Irrelevant bus inputs: databus_ready_i pulsed while idle, and rdata 0xDEADBEEF driven to a non-granted requester -> no req_ready_o pulse, no state change.
- With DATABUS_ARB_PRIORITY_EN, prio_mask_i=4'b1000, requesters 1 and 3 valid, rr pointer 0 -> grant 3 first, then 1; rr pointer becomes 2 after requester 1's last.
